// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl: tag/valid/LRU controller for a 2-way, 8-set cache with
// 8-bit addresses (tag = addr[7:3], set = addr[2:0]). The data arrays and
// the 2:1 way mux live outside this block; it only steers them.
//
// Ports:
//   clk, resetn        rising-edge clock, async active-low reset
//   req, addr          read request (accepted when req && ready)
//   flush              invalidate every line; honoured only while idle
//   memAck, memData    backing-memory fill handshake (one-cycle ack pulse)
//   ready              combinational: idle and not flushing
//   memReq, memAddr    level fill request and its address
//   setIdx             captured set index for both data arrays
//   Sel                way select for the external data mux
//   wrEn0, wrEn1       one-cycle data-array write strobes
//   fillData           registered fill data, valid with wrEn0/wrEn1
//   hit, done          completion pulse and its hit/miss qualifier
module cache_way_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic [7:0] addr,
    input  logic       flush,
    input  logic       memAck,
    input  logic [7:0] memData,
    output logic       ready,
    output logic       memReq,
    output logic [7:0] memAddr,
    output logic [2:0] setIdx,
    output logic       Sel,
    output logic       wrEn0,
    output logic       wrEn1,
    output logic [7:0] fillData,
    output logic       hit,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, FILL, RESP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            addr_q, addr_d;
    logic                  sel_q, sel_d;
    logic                  hit_q, hit_d;
    logic                  victim_q, victim_d;
    logic [7:0]            fill_q, fill_d;
    logic [7:0][1:0][4:0]  tag_q, tag_d;
    logic [7:0][1:0]       valid_q, valid_d;
    logic [7:0]            lru_q, lru_d;

    logic [2:0] set_w;
    logic [4:0] tag_w;
    logic       hit0_w, hit1_w;

    assign set_w  = addr_q[2:0];
    assign tag_w  = addr_q[7:3];
    assign hit0_w = valid_q[set_w][0] && (tag_q[set_w][0] == tag_w);
    assign hit1_w = valid_q[set_w][1] && (tag_q[set_w][1] == tag_w);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        hit_d    = hit_q;
        victim_d = victim_q;
        fill_d   = fill_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        lru_d    = lru_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (req) begin
                    addr_d  = addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit0_w || hit1_w) begin
                    // way0 takes priority if both somehow match
                    sel_d        = !hit0_w;
                    lru_d[set_w] = hit0_w;
                    hit_d        = 1'b1;
                    state_d      = RESP;
                end else begin
                    if (!valid_q[set_w][0])      victim_d = 1'b0;
                    else if (!valid_q[set_w][1]) victim_d = 1'b1;
                    else                         victim_d = lru_q[set_w];
                    hit_d   = 1'b0;
                    state_d = MISS;
                end
            end
            MISS: begin
                if (memAck) begin
                    fill_d  = memData;
                    state_d = FILL;
                end
            end
            FILL: begin
                tag_d[set_w][victim_q]   = tag_w;
                valid_d[set_w][victim_q] = 1'b1;
                lru_d[set_w]             = !victim_q;
                sel_d                    = victim_q;
                state_d                  = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sel_q    <= 1'b0;
            hit_q    <= 1'b0;
            victim_q <= 1'b0;
            fill_q   <= '0;
            tag_q    <= '0;
            valid_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            hit_q    <= hit_d;
            victim_q <= victim_d;
            fill_q   <= fill_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            lru_q    <= lru_d;
        end
    end

    // Strobes decode straight from state so reset removes them without a clock.
    assign ready    = (state_q == IDLE) && !flush;
    assign memReq   = (state_q == MISS);
    assign memAddr  = addr_q;
    assign setIdx   = addr_q[2:0];
    assign Sel      = sel_q;
    assign wrEn0    = (state_q == FILL) && !victim_q;
    assign wrEn1    = (state_q == FILL) &&  victim_q;
    assign fillData = fill_q;
    assign hit      = hit_q;
    assign done     = (state_q == RESP);

endmodule
